// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped write-through no-write-allocate D-cache for the MIPS memory stage.
// Define DCACHE_STATS_EN to add saturating hit/miss/store counters.
module mem_stage_dcache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - OB - IB;
    localparam logic [OB-1:0] LAST = OB'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESUME} state_t;
    state_t r_state, w_next;

    logic [LINES-1:0] r_valid;
    logic [TB-1:0]    r_tags [LINES];
    logic [31:0]      r_data [LINES*WORDS];
    logic [TB-1:0]    r_tag;
    logic [IB-1:0]    r_idx;
    logic [OB-1:0]    r_off, r_cnt;
    logic [31:0]      r_wdata;

    logic [TB-1:0] w_tag, w_ltag;
    logic [IB-1:0] w_idx, w_lidx;
    logic [OB-1:0] w_off, w_loff;
    logic          w_hit, w_fill_done, w_unused;

    assign w_tag  = ALUOutM[31 -: TB];
    assign w_idx  = ALUOutM[2+OB +: IB];
    assign w_off  = ALUOutM[2 +: OB];
    assign w_unused = ^ALUOutM[1:0];
    // RESUME serves the load from the latched address, ignoring input changes during the stall
    assign w_ltag = r_state == RESUME ? r_tag : w_tag;
    assign w_lidx = r_state == RESUME ? r_idx : w_idx;
    assign w_loff = r_state == RESUME ? r_off : w_off;
    assign w_hit  = r_valid[w_lidx] && r_tags[w_lidx] == w_ltag;
    assign w_fill_done = r_state == FILL && mem_ready && r_cnt == LAST;
    assign ReadDataM = (MemReadM && !MemWriteM && w_hit) ? r_data[{w_lidx, w_loff}] : '0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_idx   <= '0;
            r_off   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (MemReadM || MemWriteM)) begin
                r_tag   <= w_tag;
                r_idx   <= w_idx;
                r_off   <= w_off;
                r_wdata <= WriteDataM;
                r_cnt   <= '0;
            end
            if (r_state == FILL && mem_ready) r_cnt <= r_cnt + 1'b1;
            if (w_fill_done) r_valid[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == IDLE && MemWriteM && w_hit) r_data[{w_idx, w_off}] <= WriteDataM;
        if (r_state == FILL && mem_ready) r_data[{r_idx, r_cnt}] <= mem_rdata;
        if (w_fill_done) r_tags[r_idx] <= r_tag;
    end

    always_comb begin
        w_next    = r_state;
        StallM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            IDLE: begin
                if (MemWriteM) begin
                    StallM = 1'b1;
                    w_next = WRITE;
                end else if (MemReadM && !w_hit) begin
                    StallM = 1'b1;
                    w_next = FILL;
                end
            end
            FILL: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, r_cnt, 2'b00};
                if (w_fill_done) w_next = RESUME;
            end
            WRITE: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag, r_idx, r_off, 2'b00};
                mem_wdata = r_wdata;
                if (mem_ready) w_next = RESUME;
            end
            RESUME: w_next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count, store_count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            store_count <= '0;
        end else if (r_state == IDLE) begin
            if (MemWriteM) begin
                if (store_count != '1) store_count <= store_count + 1;
            end else if (MemReadM) begin
                if (w_hit) begin
                    if (hit_count != '1) hit_count <= hit_count + 1;
                end else if (miss_count != '1) miss_count <= miss_count + 1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb_mem_stage_dcache: directed vector bench for mem_stage_dcache with a word-addressed RAM model.
module tb_mem_stage_dcache;
    logic        CLK, reset, MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM, mem_addr, mem_wdata, mem_rdata;
    logic        StallM, mem_req, mem_we, mem_ready;

    logic [31:0] ram [1024];
    int          waits, wcnt;
    int          checks, errors;
    logic [31:0] adr_q [$];

    mem_stage_dcache dut (
        .CLK(CLK), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    assign mem_rdata = ram[mem_addr[11:2]];
    assign mem_ready = mem_req && (wcnt >= waits);

    always @(posedge CLK) begin
        wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
        if (mem_req && mem_ready && mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          st;
        int          tx;
        logic [31:0] rexp;
    } vec_t;
    vec_t v [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1; MemReadM = 0; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0;
        repeat (2) @(negedge CLK);
        reset = 0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int st, output int tx, output logic [31:0] rdat);
        MemReadM = rd; MemWriteM = wr; ALUOutM = a; WriteDataM = d;
        st = 0; tx = 0; adr_q.delete();
        #1;
        while (StallM && st < 60) begin
            st++;
            if (mem_req && mem_ready) begin
                tx++;
                adr_q.push_back(mem_addr);
            end
            @(negedge CLK); #1;
        end
        rdat = ReadDataM;
        @(negedge CLK);
        MemReadM = 0; MemWriteM = 0;
    endtask

    initial begin
        int st, tx, guard;
        logic [31:0] rdat;
        checks = 0; errors = 0; waits = 0; wcnt = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 | i;
        v[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        5, 4, 32'hA000_0040};
        v[1]  = '{1'b1, 1'b0, 32'h104, 32'h0,        0, 0, 32'hA000_0041};
        v[2]  = '{1'b0, 1'b1, 32'h7CC, 32'h1F4,      2, 1, 32'h0};
        v[3]  = '{1'b1, 1'b0, 32'h7CC, 32'h0,        5, 4, 32'h1F4};
        v[4]  = '{1'b0, 1'b1, 32'h108, 32'hDEADBEEF, 2, 1, 32'h0};
        v[5]  = '{1'b1, 1'b0, 32'h108, 32'h0,        0, 0, 32'hDEADBEEF};
        v[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,        5, 4, 32'hA000_0080};
        v[7]  = '{1'b1, 1'b0, 32'h100, 32'h0,        5, 4, 32'hA000_0040};
        v[8]  = '{1'b1, 1'b0, 32'h10C, 32'h0,        0, 0, 32'hA000_0043};
        v[9]  = '{1'b0, 1'b1, 32'h300, 32'h55,       2, 1, 32'h0};
        v[10] = '{1'b1, 1'b0, 32'h100, 32'h0,        0, 0, 32'hA000_0040};
        v[11] = '{1'b1, 1'b0, 32'h300, 32'h0,        5, 4, 32'h55};

        do_reset();
        #1;
        chk("rst_stall", {31'b0, StallM}, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            access(v[i].rd, v[i].wr, v[i].a, v[i].d, st, tx, rdat);
            chk($sformatf("v%0d_stall", i), st, v[i].st);
            chk($sformatf("v%0d_txns", i), tx, v[i].tx);
            if (v[i].rd) chk($sformatf("v%0d_rdata", i), rdat, v[i].rexp);
            if (v[i].wr && adr_q.size() > 0) chk($sformatf("v%0d_waddr", i), adr_q[0], v[i].a);
            if (i == 0 && adr_q.size() == 4)
                for (int k = 0; k < 4; k++) chk($sformatf("fill_addr%0d", k), adr_q[k], 32'h100 + 32'(4 * k));
`ifdef DCACHE_STATS_EN
            if (i == 1) begin
                chk("miss_count", dut.miss_count, 32'd1);
                chk("hit_count", dut.hit_count, 32'd1);
                chk("store_count", dut.store_count, 32'd0);
            end
`endif
        end
        chk("ram499", ram[499], 32'h1F4);
        chk("ram66", ram[66], 32'hDEADBEEF);
        chk("ram192", ram[192], 32'h55);

        do_reset();
        waits = 2;
        access(1'b1, 1'b0, 32'h100, 32'h0, st, tx, rdat);
        chk("wait_stall", st, 13);
        chk("wait_rdata", rdat, 32'hA000_0040);

        MemReadM = 1; ALUOutM = 32'h140; tx = 0; guard = 0;
        #1;
        while (tx < 2 && guard < 40) begin
            guard++;
            if (mem_req && mem_ready) tx++;
            @(negedge CLK); #1;
        end
        chk("midfill_words", tx, 2);
        reset = 1; MemReadM = 0;
        @(negedge CLK); #1;
        chk("midrst_req", {31'b0, mem_req}, 32'h0);
        chk("midrst_stall", {31'b0, StallM}, 32'h0);
        @(negedge CLK);
        reset = 0;
        waits = 0;
        access(1'b1, 1'b0, 32'h100, 32'h0, st, tx, rdat);
        chk("postrst_stall", st, 5);
        chk("postrst_rdata", rdat, 32'hA000_0040);
        access(1'b1, 1'b0, 32'h140, 32'h0, st, tx, rdat);
        chk("aborted_line_stall", st, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
